// File: rtl/syn_rst_seq_ctrl.sv
// Power-up / soft reset sequencer: synchronises the board reset, holds all domains,
// then releases each domain reset in index order, waiting (bounded) for its ready ack.
module syn_rst_seq_ctrl #(
   parameter int NUM_DOMAINS = 4,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 8,
   parameter int STAGE_DLY   = 4,
   parameter int RDY_TIMEOUT = 16,
   localparam int DOM_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
   input  logic                   clk_ir,
   input  logic                   rst_async_il,
   input  logic                   soft_rst_req_i,
   input  logic [NUM_DOMAINS-1:0] dom_rdy_i,
   output logic [NUM_DOMAINS-1:0] dom_rst_l_o,
   output logic                   seq_busy_o,
   output logic                   seq_done_o,
   output logic [DOM_W-1:0]       cur_dom_o,
   output logic [NUM_DOMAINS-1:0] timeout_err_o
);

   localparam int MAX_A   = (HOLD_CYCLES > STAGE_DLY) ? HOLD_CYCLES : STAGE_DLY;
   localparam int MAX_CNT = (MAX_A > RDY_TIMEOUT) ? MAX_A : RDY_TIMEOUT;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(STAGE_DLY);
   localparam logic [CNT_W-1:0] RDY_LD   = CNT_W'(RDY_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [DOM_W-1:0] LAST_DOM = DOM_W'(NUM_DOMAINS - 1);

   typedef enum logic [1:0] {
      ST_HOLD     = 2'd0,
      ST_WAIT_RDY = 2'd1,
      ST_GAP      = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   rst_sync_l_r;

   state_t                 state_r, state_s;
   logic [CNT_W-1:0]       cnt_r, cnt_s;
   logic [NUM_DOMAINS-1:0] dom_rst_r, dom_rst_s;
   logic [NUM_DOMAINS-1:0] err_r, err_s;
   logic [DOM_W-1:0]       cur_r, cur_s;
   logic [DOM_W-1:0]       nxt_dom_s;
   logic                   busy_r, busy_s;
   logic                   done_r, done_s;

   assign nxt_dom_s = cur_r + DOM_W'(1);

   // Reset synchroniser; the retiming flop makes rst_sync_l rise SYNC_STAGES edges after edge 0
   always_ff @(posedge clk_ir or negedge rst_async_il) begin
      if (!rst_async_il) begin
         sync_r       <= '0;
         rst_sync_l_r <= 1'b0;
      end else begin
         sync_r       <= {sync_r[SYNC_STAGES-2:0], 1'b1};
         rst_sync_l_r <= sync_r[SYNC_STAGES-1];
      end
   end

   // Sequencer state register; every output comes straight from here
   always_ff @(posedge clk_ir or negedge rst_async_il) begin
      if (!rst_async_il) begin
         state_r   <= ST_HOLD;
         cnt_r     <= HOLD_LD;
         dom_rst_r <= '0;
         err_r     <= '0;
         cur_r     <= '0;
         busy_r    <= 1'b1;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         dom_rst_r <= dom_rst_s;
         err_r     <= err_s;
         cur_r     <= cur_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
      end
   end

   // Next-state logic; a soft request overrides any ready/timeout at the same edge
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      dom_rst_s = dom_rst_r;
      err_s     = err_r;
      cur_s     = cur_r;
      busy_s    = busy_r;
      done_s    = done_r;
      if (soft_rst_req_i) begin
         state_s   = ST_HOLD;
         cnt_s     = HOLD_LD;
         dom_rst_s = '0;
         err_s     = '0;
         cur_s     = '0;
         busy_s    = 1'b1;
         done_s    = 1'b0;
      end else begin
         case (state_r)
            ST_HOLD: begin
               if (!rst_sync_l_r) begin
                  cnt_s = HOLD_LD;
               end else if (cnt_r <= CNT_ONE) begin
                  dom_rst_s[0] = 1'b1;
                  cur_s        = '0;
                  cnt_s        = RDY_LD;
                  state_s      = ST_WAIT_RDY;
               end else begin
                  cnt_s = cnt_r - CNT_ONE;
               end
            end
            ST_WAIT_RDY: begin
               if (dom_rdy_i[cur_r] || (cnt_r <= CNT_ONE)) begin
                  if (!dom_rdy_i[cur_r]) begin
                     err_s[cur_r] = 1'b1;
                  end else begin
                     err_s = err_r;
                  end
                  if (cur_r == LAST_DOM) begin
                     state_s = ST_DONE;
                     busy_s  = 1'b0;
                     done_s  = 1'b1;
                  end else begin
                     state_s = ST_GAP;
                     cnt_s   = GAP_LD;
                  end
               end else begin
                  cnt_s = cnt_r - CNT_ONE;
               end
            end
            ST_GAP: begin
               if (cnt_r <= CNT_ONE) begin
                  dom_rst_s[nxt_dom_s] = 1'b1;
                  cur_s                = nxt_dom_s;
                  cnt_s                = RDY_LD;
                  state_s              = ST_WAIT_RDY;
               end else begin
                  cnt_s = cnt_r - CNT_ONE;
               end
            end
            ST_DONE: begin
               state_s = ST_DONE;
            end
            default: begin
               state_s = ST_HOLD;
               cnt_s   = HOLD_LD;
            end
         endcase
      end
   end

   assign dom_rst_l_o   = dom_rst_r;
   assign seq_busy_o    = busy_r;
   assign seq_done_o    = done_r;
   assign cur_dom_o     = cur_r;
   assign timeout_err_o = err_r;

endmodule

// File: tb/tb_syn_rst_seq_ctrl.sv
// Bench for syn_rst_seq_ctrl: an edge-numbered event model checked every cycle,
// plus directed literal checks at the hand-derived edges.
module tb_syn_rst_seq_ctrl;

   localparam int ND   = 4;
   localparam int SYNC = 2;
   localparam int HOLD = 8;
   localparam int GAP  = 4;
   localparam int TO   = 16;

   logic          clk_ir = 1'b0;
   logic          rst_async_il = 1'b0;
   logic          soft_rst_req_i = 1'b0;
   logic [ND-1:0] dom_rdy_i = 4'hF;
   logic [ND-1:0] dom_rst_l_o;
   logic          seq_busy_o;
   logic          seq_done_o;
   logic [1:0]    cur_dom_o;
   logic [ND-1:0] timeout_err_o;

   int checks = 0;
   int passed = 0;
   bit cmp_en = 1'b0;

   syn_rst_seq_ctrl #(
      .NUM_DOMAINS(ND), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD),
      .STAGE_DLY(GAP), .RDY_TIMEOUT(TO)
   ) dut (
      .clk_ir(clk_ir), .rst_async_il(rst_async_il), .soft_rst_req_i(soft_rst_req_i),
      .dom_rdy_i(dom_rdy_i), .dom_rst_l_o(dom_rst_l_o), .seq_busy_o(seq_busy_o),
      .seq_done_o(seq_done_o), .cur_dom_o(cur_dom_o), .timeout_err_o(timeout_err_o)
   );

   always #5 clk_ir = ~clk_ir;

   // Model: absolute edge numbers for every release / deadline
   int            n;
   logic [ND-1:0] m_rst, m_err;
   logic          m_busy, m_done;
   int            m_cur, rel_at, nxt, deadline;
   bit            waiting;

   function automatic void model_reset();
      m_rst = '0; m_err = '0; m_busy = 1'b1; m_done = 1'b0; m_cur = 0;
      n = -1; rel_at = SYNC + HOLD; nxt = 0; waiting = 1'b0;
   endfunction

   always @(negedge rst_async_il) model_reset();

   always @(posedge clk_ir) begin
      if (!rst_async_il) begin
         model_reset();
      end else begin
         n++;
         if (soft_rst_req_i) begin
            m_rst = '0; m_err = '0; m_busy = 1'b1; m_done = 1'b0; m_cur = 0;
            nxt = 0; waiting = 1'b0; rel_at = n + HOLD;
         end else if (waiting) begin
            if (dom_rdy_i[m_cur] || n == deadline) begin
               if (!dom_rdy_i[m_cur]) m_err[m_cur] = 1'b1;
               waiting = 1'b0;
               if (m_cur == ND - 1) begin
                  m_done = 1'b1; m_busy = 1'b0;
               end else begin
                  nxt = m_cur + 1; rel_at = n + GAP;
               end
            end
         end else if (!m_done && n == rel_at) begin
            m_rst[nxt] = 1'b1; m_cur = nxt; waiting = 1'b1; deadline = n + TO;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s edge=%0d actual=%h required=%h", name, n, act, exp);
   endtask

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk_ir) begin
      if (cmp_en)
         chk("cycle", {20'd0, dom_rst_l_o, seq_busy_o, seq_done_o, cur_dom_o, timeout_err_o},
             {20'd0, m_rst, m_busy, m_done, 2'(m_cur), m_err});
   end

   task automatic at_edge(input int e);
      int guard = 0;
      while (n != e && guard < 500) begin
         @(posedge clk_ir); #1;
         guard++;
      end
      if (n != e) chk("edge_wait", 32'(n), 32'(e));
   endtask

   task automatic soft_pulse(input logic [ND-1:0] rdy);
      @(negedge clk_ir); soft_rst_req_i = 1'b1; dom_rdy_i = rdy;
      @(negedge clk_ir); soft_rst_req_i = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk_ir);
      cmp_en = 1'b1;
      chk("rst_dom", 32'(dom_rst_l_o), 32'h0);
      chk("rst_busy", 32'(seq_busy_o), 32'h1);
      rst_async_il = 1'b1;                         // next posedge is edge 0

      // Power-up, all ready
      at_edge(9);  chk("t1_dom_e9", 32'(dom_rst_l_o), 32'h0);
      at_edge(10); chk("t1_dom_e10", 32'(dom_rst_l_o), 32'h1);
      at_edge(15); chk("t1_dom_e15", 32'(dom_rst_l_o), 32'h3);
      at_edge(20); chk("t1_dom_e20", 32'(dom_rst_l_o), 32'h7);
      at_edge(25); chk("t1_dom_e25", 32'(dom_rst_l_o), 32'hF);
      chk("t1_done_e25", 32'(seq_done_o), 32'h0);
      at_edge(26); chk("t1_done_e26", 32'(seq_done_o), 32'h1);
      chk("t1_busy_e26", 32'(seq_busy_o), 32'h0);
      chk("t1_err", 32'(timeout_err_o), 32'h0);

      // Ready dropped after DONE has no effect
      @(negedge clk_ir); dom_rdy_i = 4'h0;
      at_edge(30); chk("t6_done", 32'(seq_done_o), 32'h1);
      chk("t6_dom", 32'(dom_rst_l_o), 32'hF);

      // Soft request in DONE at edge 31
      soft_pulse(4'hF);
      at_edge(31); chk("t3_dom_S", 32'(dom_rst_l_o), 32'h0);
      chk("t3_done_S", 32'(seq_done_o), 32'h0);
      at_edge(38); chk("t3_dom_S7", 32'(dom_rst_l_o), 32'h0);
      at_edge(39); chk("t3_dom_S8", 32'(dom_rst_l_o), 32'h1);
      at_edge(55); chk("t3_done", 32'(seq_done_o), 32'h1);

      // Dom1 times out, then soft request while waiting on dom2 (S=56, S2=95)
      soft_pulse(4'b1001);
      at_edge(84); chk("t4_err_e84", 32'(timeout_err_o), 32'h0);
      at_edge(85); chk("t4_err_e85", 32'(timeout_err_o), 32'h2);
      at_edge(89); chk("t4_dom_e89", 32'(dom_rst_l_o), 32'h7);
      at_edge(94);
      soft_pulse(4'hF);
      at_edge(95); chk("t4_err_S", 32'(timeout_err_o), 32'h0);
      chk("t4_dom_S", 32'(dom_rst_l_o), 32'h0);
      at_edge(103); chk("t4_dom_restart", 32'(dom_rst_l_o), 32'h1);

      // Async reset mid-GAP, between edges
      at_edge(111); chk("t5_dom_gap", 32'(dom_rst_l_o), 32'h3);
      #3 rst_async_il = 1'b0;
      #1 chk("t5_dom_async", 32'(dom_rst_l_o), 32'h0);
      chk("t5_busy_async", 32'(seq_busy_o), 32'h1);
      repeat (2) @(negedge clk_ir);
      dom_rdy_i = 4'b1011;
      rst_async_il = 1'b1;

      // Power-up again with dom2 stuck not-ready
      at_edge(9);  chk("t2_dom_e9", 32'(dom_rst_l_o), 32'h0);
      at_edge(10); chk("t2_dom_e10", 32'(dom_rst_l_o), 32'h1);
      at_edge(15); chk("t2_dom_e15", 32'(dom_rst_l_o), 32'h3);
      at_edge(20); chk("t2_dom_e20", 32'(dom_rst_l_o), 32'h7);
      at_edge(35); chk("t2_err_e35", 32'(timeout_err_o), 32'h0);
      at_edge(36); chk("t2_err_e36", 32'(timeout_err_o), 32'h4);
      at_edge(39); chk("t2_dom_e39", 32'(dom_rst_l_o), 32'h7);
      at_edge(40); chk("t2_dom_e40", 32'(dom_rst_l_o), 32'hF);
      chk("t2_done_e40", 32'(seq_done_o), 32'h0);
      at_edge(41); chk("t2_done_e41", 32'(seq_done_o), 32'h1);
      chk("t2_cur", 32'(cur_dom_o), 32'h3);

      repeat (3) @(negedge clk_ir);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
